// File: rtl/dmem_access_unit_if.sv
// Request/response bundle between the issuing pipeline stage and dmem_access_unit.
// The master drives a request and the slave (the unit) returns completion and load data.
interface dmem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        rvalid;
    logic        done;
    logic        fault;

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, wdata,
        input  req_ready, rdata, rvalid, done, fault
    );

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, wdata,
        output req_ready, rdata, rvalid, done, fault
    );
endinterface

// File: rtl/dmem_access_unit.sv
// RV64 data-memory stage: doubleword RAM with byte-lane stores and sign/zero-extended loads.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of being force-aligned.
module dmem_access_unit #(
    parameter int DEPTH = 512,
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    dmem_access_unit_if.slave bus
);
    localparam int AW = IDX_W + 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;

    logic [63:0]   mem [DEPTH];
    logic [63:0]   word_q;

    // Request decode on the live inputs, evaluated in the accept cycle
    logic [2:0]    amask;
    logic          out_of_range;
    logic          is_mem;
    logic          misaligned;
    logic          req_fault;
    logic [AW-1:0] req_addr;

    always_comb begin
        case (bus.funct3[1:0])
            2'd0:    amask = 3'b000;
            2'd1:    amask = 3'b001;
            2'd2:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
    end

    assign out_of_range = |bus.addr[63:AW];
    assign is_mem       = bus.mem_read | bus.mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = |(bus.addr[2:0] & amask);
    assign req_addr   = bus.addr[AW-1:0];
`else
    assign misaligned = 1'b0;
    assign req_addr   = {bus.addr[AW-1:3], bus.addr[2:0] & ~amask};
`endif

    assign req_fault = (bus.mem_read & bus.mem_write)
                     | (is_mem & (out_of_range | misaligned))
                     | (bus.mem_read & (bus.funct3 == 3'b111));

    // Store lane enables and data, shifted into the addressed byte lanes
    logic [2:0]       off;
    logic [IDX_W-1:0] idx;
    logic [7:0]       be;
    logic [7:0]       be_shift;
    logic [63:0]      wshift;

    assign off = addr_q[2:0];
    assign idx = addr_q[AW-1:3];

    always_comb begin
        case (funct3_q[1:0])
            2'd0:    be = 8'h01;
            2'd1:    be = 8'h03;
            2'd2:    be = 8'h0F;
            default: be = 8'hFF;
        endcase
    end

    assign be_shift = be << off;
    assign wshift   = wdata_q << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (state_q == ACCESS) begin
            if (wr_q) begin
                for (int i = 0; i < 8; i++) begin
                    if (be_shift[i]) mem[idx][i*8 +: 8] <= wshift[i*8 +: 8];
                end
            end
            if (rd_q) word_q <= mem[idx];
        end
    end

    // Load lane select and extension from the registered doubleword
    logic [63:0] lshift;
    logic [63:0] load_data;

    assign lshift = word_q >> {off, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{56{lshift[7]}},  lshift[7:0]};
            3'b001:  load_data = {{48{lshift[15]}}, lshift[15:0]};
            3'b010:  load_data = {{32{lshift[31]}}, lshift[31:0]};
            3'b100:  load_data = {56'd0, lshift[7:0]};
            3'b101:  load_data = {48'd0, lshift[15:0]};
            3'b110:  load_data = {32'd0, lshift[31:0]};
            default: load_data = lshift;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = bus.funct3;
                    wdata_d  = bus.wdata;
                    rd_d     = bus.mem_read;
                    wr_d     = bus.mem_write;
                    state_d  = req_fault ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                if (rd_q) begin
                    state_d = RESP;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP: begin
                rdata_d  = load_data;
                rvalid_d = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                done_d  = 1'b1;
                fault_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
endmodule
